hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Issue/sequencing controller between the instruction-decode stage and the execute stage of the Hack CPU pipeline.
- Holds a scoreboard of in-flight writers to A, D and M and stalls decode on read-after-write hazards.
- Serialises conditional jumps: no issue while a jump is unresolved.
- On a taken jump it drives the stage invalidate (flush) and a PC redirect to fetch.

Parameters:
PC_W, 15, width of program counter / redirect target
MAX_INFLIGHT, 3, max outstanding writers per register; scoreboard counter width = clog2(MAX_INFLIGHT+1)
FLUSH_CYCLES, 1, cycles flush stays asserted after a taken jump (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
dec_vld  in  1  decoded instruction valid
dec_gnt  out  1  decoded instruction accepted (issued) this cycle
dec_rd_a  in  1  instruction reads A (operand, M address or jump target)
dec_rd_d  in  1  instruction reads D
dec_rd_m  in  1  instruction reads M
dec_wr  in  3  destination bits {A,D,M}
dec_jcond  in  3  jump condition; non-zero = jump instruction
ex_gnt  in  1  execute stage can accept
iss_vld  out  1  issue strobe to execute (== dec_gnt)
wb_vld  in  1  writeback retire strobe
wb_dst  in  3  retiring destination bits {A,D,M}
br_vld  in  1  jump resolution strobe from execute
br_taken  in  1  jump taken (qualified by br_vld)
br_tgt  in  PC_W  jump target (qualified by br_vld)
flush  out  1  invalidate to fetch and decode
redir_vld  out  1  one-cycle PC redirect strobe
redir_pc  out  PC_W  redirect target
err  out  1  sticky protocol error
busy  out  3  {A,D,M} scoreboard non-zero (debug)

Behaviour:
- Reset: state RUN; all counters 0; flush, redir_vld, err, dec_gnt, iss_vld = 0; redir_pc = 0.
- Counters: cnt_a, cnt_d, cnt_m.
  - +1 on issue with the matching dec_wr bit; -1 on wb_vld with the matching wb_dst bit.
  - Simultaneous +1 and -1 on the same counter: unchanged.
- Hazard: (dec_rd_a & cnt_a!=0) | (dec_rd_d & cnt_d!=0) | (dec_rd_m & cnt_m!=0).
- Saturation stall: any dec_wr bit set whose counter == MAX_INFLIGHT.
- Issue (combinational): dec_gnt = iss_vld = dec_vld & ex_gnt & state==RUN & ~hazard & ~sat & ~rst.
  - Zero-cycle latency from decode to execute handshake.
- States:
  - RUN: issue allowed. Issue with dec_jcond!=0 -> BR_WAIT next cycle.
  - BR_WAIT: no issue.
    - br_vld & ~br_taken -> RUN.
    - br_vld & br_taken -> FLUSH; redir_vld=1 and redir_pc=br_tgt registered, visible for exactly one cycle on FLUSH entry.
  - FLUSH: flush=1 (registered) for FLUSH_CYCLES cycles, then RUN. No issue while flush=1.
- Scoreboard is not cleared on flush: writers issued before the jump are older and retire normally.
- Errors (err set, sticky until rst):
  - br_vld outside BR_WAIT: event ignored.
  - wb_vld retiring a register whose counter is 0: counter stays 0.
- Retire and issue to the same register in one cycle while count is 0: net +1; no error.
- rst mid-operation (any state, any counts): returns to the reset values next edge; pending jump discarded, flush deasserts.

Optional Feature:
- Macro HAZARD_CTRL_WB_BYPASS_EN.
- Defined: hazard evaluated with same-cycle retire credit. A register is treated free if its counter == 1 and wb_vld retires it this cycle, so the dependent instruction issues in the retire cycle.
- Undefined: hazard uses registered counters only; the dependent instruction issues one cycle after retire.

Decomposition:
- CpuPkg:
  - enum hz_state_e {RUN, BR_WAIT, FLUSH}
  - localparams DST_A=2, DST_D=1, DST_M=0
  - PC_W default
- Sub-module sb_counter (parameter MAX_INFLIGHT):
  - inputs inc, dec
  - outputs cnt, nz, sat, underflow
  - instantiated three times.

Test Plan:
- Reset then dec_vld=1, dec_wr=3'b010, ex_gnt=1 -> iss_vld=1 same cycle; busy=3'b010 next cycle.
- RAW on D:
  - Issue D-writer, next cycle dec_rd_d=1 -> dec_gnt=0 until wb_vld with wb_dst=3'b010.
  - Issue one cycle after retire without HAZARD_CTRL_WB_BYPASS_EN; in the retire cycle with it.
- Saturation: MAX_INFLIGHT=3, issue three A-writers with no retire -> fourth A-writer stalled; single wb_vld A -> fourth issues.
- Taken jump:
  - Issue dec_jcond=3'b111 -> stall.
  - br_vld=1, br_taken=1, br_tgt=15'h0123 -> next cycle redir_vld=1, redir_pc=15'h0123, flush=1 for 1 cycle, then RUN issue resumes.
- Not-taken jump: br_vld=1, br_taken=0 -> no flush, no redir_vld, issue resumes next cycle.
- Errors/reset:
  - br_vld in RUN -> err=1 sticky.
  - wb_vld A with cnt_a=0 -> err=1, cnt_a stays 0.
  - rst asserted in BR_WAIT -> state RUN, busy=0, err=0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the Hack CPU issue/hazard controller
package hazard_ctrl_pkg;
    typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} hz_state_e;
    localparam int DST_A = 2;
    localparam int DST_D = 1;
    localparam int DST_M = 0;
    localparam int PC_W_DEF = 15;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/execute/writeback/branch signals between the pipeline (master) and hazard_ctrl (slave)
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(parameter int PC_W = PC_W_DEF);
    logic            dec_vld;
    logic            dec_gnt;
    logic            dec_rd_a;
    logic            dec_rd_d;
    logic            dec_rd_m;
    logic [2:0]      dec_wr;
    logic [2:0]      dec_jcond;
    logic            ex_gnt;
    logic            iss_vld;
    logic            wb_vld;
    logic [2:0]      wb_dst;
    logic            br_vld;
    logic            br_taken;
    logic [PC_W-1:0] br_tgt;
    logic            flush;
    logic            redir_vld;
    logic [PC_W-1:0] redir_pc;
    logic            err;
    logic [2:0]      busy;
    modport master (
        output dec_vld, dec_rd_a, dec_rd_d, dec_rd_m, dec_wr, dec_jcond, ex_gnt,
               wb_vld, wb_dst, br_vld, br_taken, br_tgt,
        input  dec_gnt, iss_vld, flush, redir_vld, redir_pc, err, busy
    );
    modport slave (
        input  dec_vld, dec_rd_a, dec_rd_d, dec_rd_m, dec_wr, dec_jcond, ex_gnt,
               wb_vld, wb_dst, br_vld, br_taken, br_tgt,
        output dec_gnt, iss_vld, flush, redir_vld, redir_pc, err, busy
    );
endinterface

// File: rtl/hazard_ctrl_sb_counter.sv
// sb_counter: per-register count of in-flight writers; a retire landing on an empty counter alongside an issue still nets +1
module sb_counter #(
    parameter int MAX_INFLIGHT = 3,
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          nz_o,
    output logic          sat_o,
    output logic          underflow_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_o       = cnt_q;
    assign nz_o        = cnt_q != '0;
    assign sat_o       = cnt_q == CW'(MAX_INFLIGHT);
    assign underflow_o = dec_i & ~inc_i & ~nz_o;

    // next count: issue wins over a retire that has nothing to retire
    always_comb begin
        cnt_d = (inc_i && (!dec_i || !nz_o)) ? cnt_q + CW'(1) :
                (dec_i && !inc_i && nz_o)    ? cnt_q - CW'(1) : cnt_q;
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode->execute issue control with A/D/M scoreboard, jump serialisation and flush/redirect; option HAZARD_CTRL_WB_BYPASS_EN
module hazard_ctrl import hazard_ctrl_pkg::*; #(
    parameter int PC_W         = PC_W_DEF,
    parameter int MAX_INFLIGHT = 3,
    parameter int FLUSH_CYCLES = 1
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hc
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
`ifdef HAZARD_CTRL_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    hz_state_e       state_q, state_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            redir_vld_q, redir_vld_d;
    logic [PC_W-1:0] redir_pc_q, redir_pc_d;
    logic            err_q, err_d;

    logic [2:0]    rd, inc, dec, nz, sat, uf, credit;
    logic [CW-1:0] cnt [3];
    logic          hazard, sat_stall, gnt;

    assign rd[DST_A] = hc.dec_rd_a;
    assign rd[DST_D] = hc.dec_rd_d;
    assign rd[DST_M] = hc.dec_rd_m;
    assign dec       = {3{hc.wb_vld}} & hc.wb_dst;
    assign inc       = {3{gnt}} & hc.dec_wr;

    for (genvar i = 0; i < 3; i++) begin : g_sb
        sb_counter #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc[i]),
            .dec_i       (dec[i]),
            .cnt_o       (cnt[i]),
            .nz_o        (nz[i]),
            .sat_o       (sat[i]),
            .underflow_o (uf[i])
        );
        assign credit[i] = BYPASS & dec[i] & (cnt[i] == CW'(1));
    end

    assign hazard    = |(rd & nz & ~credit);
    assign sat_stall = |(hc.dec_wr & sat);
    assign gnt       = hc.dec_vld & hc.ex_gnt & (state_q == RUN) & ~hazard & ~sat_stall & ~rst;

    assign hc.dec_gnt   = gnt;
    assign hc.iss_vld   = gnt;
    assign hc.flush     = state_q == FLUSH;
    assign hc.redir_vld = redir_vld_q;
    assign hc.redir_pc  = redir_pc_q;
    assign hc.err       = err_q;
    assign hc.busy      = nz;

    // sequencing: park after an issued jump, then resume or flush on resolution
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        redir_vld_d = 1'b0;
        redir_pc_d  = redir_pc_q;
        err_d       = err_q | (hc.br_vld & (state_q != BR_WAIT)) | (|uf);
        case (state_q)
            RUN:     state_d = (gnt && hc.dec_jcond != 3'b000) ? BR_WAIT : RUN;
            BR_WAIT: begin
                if (hc.br_vld) begin
                    state_d     = hc.br_taken ? FLUSH : RUN;
                    fcnt_d      = '0;
                    redir_vld_d = hc.br_taken;
                    redir_pc_d  = hc.br_taken ? hc.br_tgt : redir_pc_q;
                end
            end
            FLUSH: begin
                fcnt_d  = fcnt_q + FW'(1);
                state_d = (fcnt_q == FW'(FLUSH_CYCLES - 1)) ? RUN : FLUSH;
            end
            default: state_d = RUN;
        endcase
    end

    // control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus hand sequences for hazard_ctrl
module tb_hazard_ctrl;
`ifdef HAZARD_CTRL_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic        r, dv, eg;
        logic [2:0]  rd, wr, jc;
        logic        wv;
        logic [2:0]  wd;
        logic        bv, bt;
        logic [14:0] tgt;
        logic        g;
        logic [2:0]  busy;
        logic        fl, rv, er;
        logic [14:0] pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];

    hazard_ctrl_if #(.PC_W(15)) hc();

    hazard_ctrl #(.PC_W(15), .MAX_INFLIGHT(3), .FLUSH_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .hc  (hc)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic r, input logic dv, input logic eg,
                                input logic [2:0] rd, input logic [2:0] wr, input logic [2:0] jc,
                                input logic wv, input logic [2:0] wd, input logic bv, input logic bt,
                                input logic [14:0] tgt, input logic g, input logic [2:0] busy,
                                input logic fl, input logic rv, input logic er, input logic [14:0] pc);
        vec_t v;
        v.nm = nm; v.r = r; v.dv = dv; v.eg = eg; v.rd = rd; v.wr = wr; v.jc = jc;
        v.wv = wv; v.wd = wd; v.bv = bv; v.bt = bt; v.tgt = tgt;
        v.g = g; v.busy = busy; v.fl = fl; v.rv = rv; v.er = er; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst          = v.r;
        hc.dec_vld   = v.dv;
        hc.ex_gnt    = v.eg;
        hc.dec_rd_a  = v.rd[2];
        hc.dec_rd_d  = v.rd[1];
        hc.dec_rd_m  = v.rd[0];
        hc.dec_wr    = v.wr;
        hc.dec_jcond = v.jc;
        hc.wb_vld    = v.wv;
        hc.wb_dst    = v.wd;
        hc.br_vld    = v.bv;
        hc.br_taken  = v.bt;
        hc.br_tgt    = v.tgt;
        #1;
        chk({v.nm, ".dec_gnt"}, 32'(hc.dec_gnt), 32'(v.g));
        chk({v.nm, ".iss_vld"}, 32'(hc.iss_vld), 32'(v.g));
        @(posedge clk);
        #1;
        chk({v.nm, ".busy"}, 32'(hc.busy), 32'(v.busy));
        chk({v.nm, ".flush"}, 32'(hc.flush), 32'(v.fl));
        chk({v.nm, ".redir_vld"}, 32'(hc.redir_vld), 32'(v.rv));
        chk({v.nm, ".redir_pc"}, 32'(hc.redir_pc), 32'(v.pc));
        chk({v.nm, ".err"}, 32'(hc.err), 32'(v.er));
    endtask

    initial begin
        //                  nm           r dv eg rd wr jc wv wd bv bt tgt       g    busy fl rv er pc
        vecs.push_back(mk("reset",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0,    0,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("iss_d",      0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 15'h0,    1,   2,   0, 0, 0, 15'h0));
        vecs.push_back(mk("raw_d",      0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 15'h0,    0,   2,   0, 0, 0, 15'h0));
        vecs.push_back(mk("raw_ret",    0, 1, 1, 2, 0, 0, 1, 2, 0, 0, 15'h0,    BYP, 0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("raw_go",     0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 15'h0,    1,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("ex_hold",    0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 15'h0,    0,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("sat1",       0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 15'h0,    1,   4,   0, 0, 0, 15'h0));
        vecs.push_back(mk("sat2",       0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 15'h0,    1,   4,   0, 0, 0, 15'h0));
        vecs.push_back(mk("sat3",       0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 15'h0,    1,   4,   0, 0, 0, 15'h0));
        vecs.push_back(mk("sat_stall",  0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 15'h0,    0,   4,   0, 0, 0, 15'h0));
        vecs.push_back(mk("sat_ret",    0, 1, 1, 0, 4, 0, 1, 4, 0, 0, 15'h0,    0,   4,   0, 0, 0, 15'h0));
        vecs.push_back(mk("sat_go",     0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 15'h0,    1,   4,   0, 0, 0, 15'h0));
        vecs.push_back(mk("ret_a3",     0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 15'h0,    0,   4,   0, 0, 0, 15'h0));
        vecs.push_back(mk("inc_dec",    0, 1, 1, 0, 4, 0, 1, 4, 0, 0, 15'h0,    1,   4,   0, 0, 0, 15'h0));
        vecs.push_back(mk("ret_a2",     0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 15'h0,    0,   4,   0, 0, 0, 15'h0));
        vecs.push_back(mk("ret_a1",     0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 15'h0,    0,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("zero_id",    0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 15'h0,    1,   1,   0, 0, 0, 15'h0));
        vecs.push_back(mk("ret_m",      0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 15'h0,    0,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("jmp",        0, 1, 1, 0, 0, 7, 0, 0, 0, 0, 15'h0,    1,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("br_wait",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0,    0,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("taken",      0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 15'h0123, 0,   0,   1, 1, 0, 15'h0123));
        vecs.push_back(mk("flushing",   0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0,    0,   0,   0, 0, 0, 15'h0123));
        vecs.push_back(mk("resume",     0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0,    1,   0,   0, 0, 0, 15'h0123));
        vecs.push_back(mk("jmp_nt",     0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 15'h0,    1,   0,   0, 0, 0, 15'h0123));
        vecs.push_back(mk("not_taken",  0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 15'h7fff, 0,   0,   0, 0, 0, 15'h0123));
        vecs.push_back(mk("resume_nt",  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0,    1,   0,   0, 0, 0, 15'h0123));
        vecs.push_back(mk("br_in_run",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 15'h0055, 0,   0,   0, 0, 1, 15'h0123));
        vecs.push_back(mk("err_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0,    0,   0,   0, 0, 1, 15'h0123));
        vecs.push_back(mk("rst_err",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0,    0,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("uflow",      0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 15'h0,    0,   0,   0, 0, 1, 15'h0));
        vecs.push_back(mk("uflow_stk",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0,    0,   0,   0, 0, 1, 15'h0));
        vecs.push_back(mk("rst_uf",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0,    0,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("jmp_d",      0, 1, 1, 0, 2, 2, 0, 0, 0, 0, 15'h0,    1,   2,   0, 0, 0, 15'h0));
        vecs.push_back(mk("rst_bw",     1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0,    0,   0,   0, 0, 0, 15'h0));
        vecs.push_back(mk("after_rst",  0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 15'h0,    1,   0,   0, 0, 0, 15'h0));
        foreach (vecs[i]) apply(vecs[i]);

        apply(mk("hs_jmp",   0, 1, 1, 0, 1, 7, 0, 0, 0, 0, 15'h0,    1, 1, 0, 0, 0, 15'h0));
        apply(mk("hs_taken", 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 15'h02aa, 0, 1, 1, 1, 0, 15'h02aa));
        apply(mk("hs_rst_fl",1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0,    0, 0, 0, 0, 0, 15'h0));
        apply(mk("hs_go",    0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 15'h0,    1, 1, 0, 0, 0, 15'h0));
        apply(mk("hs_raw_m", 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 15'h0,    0, 1, 0, 0, 0, 15'h0));
        apply(mk("hs_ret_m", 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 15'h0,    BYP, 0, 0, 0, 0, 15'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
